// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundles the controller <-> datapath signals of the RV32I multicycle core.
//   master : the control FSM (consumes instruction fields and ALU flags,
//            drives datapath enables, mux selects, ALUControl and debug State)
//   slave  : the datapath side (mirror directions)
// Signals: Op/funct3/funct7b5 from the instruction register; Zero/Negative/
//   Carry/Overflow from the ALU; PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State.
interface multicycle_ctrl_if #(
  parameter int unsigned STATE_W = 4
);
  logic [6:0]         Op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               Zero;
  logic               Negative;
  logic               Carry;
  logic               Overflow;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ImmSrc;
  logic [3:0]         ALUControl;
  logic               IllegalOp;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, funct3, funct7b5, Zero, Negative, Carry, Overflow,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
  );

  modport slave (
    output Op, funct3, funct7b5, Zero, Negative, Carry, Overflow,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main control FSM of the RV32I multicycle core. Steps the shared datapath
// through fetch/decode/execute/memory/writeback, decodes ALUControl and
// resolves branches from the ALU flags.
// Ports:
//   clk    core clock, rising edge
//   rst_n  synchronous reset, active low (returns to FETCH)
//   bus    multicycle_ctrl_if.master: instruction fields + ALU flags in,
//          datapath enables/selects, ALUControl, ImmSrc, IllegalOp, State out
module multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  // FETCH is the first member and therefore encodes as 0 on the State port.
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR,
    EXECI, ALUWB, JAL, JALR, JALRPC, BRANCH, LUI_S, AUIPC_S
  } state_t;

  typedef struct packed {
    logic       pc_write;   // unconditional PC enable
    logic       branch;     // PC enable qualified by the branch condition
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
  } ctl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;

  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;
  logic   op_legal;
  logic   taken;

  function automatic ctl_t moore_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_write = 1'b1;
      end
      DECODE:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMRD:   c.adr_src = 1'b1;
      MEMWB:   begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWR:   begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECR:   c.alu_src_a = 2'b10;
      EXECI:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      ALUWB:   c.reg_write = 1'b1;
      JAL, JALRPC: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
      JALR:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      BRANCH:  begin c.alu_src_a = 2'b10; c.branch = 1'b1; end
      LUI_S:   begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
      AUIPC_S: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = 1'b1;
    state_d  = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_REG:            state_d = EXECR;
          OP_IMM:            state_d = EXECI;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_BRANCH:         state_d = BRANCH;
          OP_LUI:            state_d = LUI_S;
          OP_AUIPC:          state_d = AUIPC_S;
          default: begin
            state_d  = FETCH;
            op_legal = 1'b0;
          end
        endcase
      end
      MEMADR:  state_d = (bus.Op == OP_LOAD) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECR, EXECI, JAL, JALRPC, LUI_S, AUIPC_S: state_d = ALUWB;
      JALR:    state_d = JALRPC;
      default: state_d = FETCH;  // MEMWB, MEMWR, ALUWB, BRANCH, unused codes
    endcase
    // Moore outputs are registered by decoding the next state, so ctl_q is
    // always the decode of state_q with no output glitches.
    ctl_d = moore_ctl(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctl_q   <= moore_ctl(FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = ~bus.Zero;
      3'b100:  taken = bus.Negative ^ bus.Overflow;
      3'b101:  taken = ~(bus.Negative ^ bus.Overflow);
      3'b110:  taken = ~bus.Carry;
      3'b111:  taken = bus.Carry;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    bus.ALUControl = ALU_ADD;
    if (state_q == EXECR || state_q == EXECI) begin
      case (bus.funct3)
        3'b000:  bus.ALUControl = (state_q == EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  bus.ALUControl = ALU_SLL;
        3'b010:  bus.ALUControl = ALU_SLT;
        3'b011:  bus.ALUControl = ALU_SLTU;
        3'b100:  bus.ALUControl = ALU_XOR;
        3'b101:  bus.ALUControl = bus.funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  bus.ALUControl = ALU_OR;
        default: bus.ALUControl = ALU_AND;
      endcase
    end else if (state_q == BRANCH) begin
      bus.ALUControl = ALU_SUB;
    end
  end

  always_comb begin
    case (bus.Op)
      OP_STORE:          bus.ImmSrc = 3'b001;
      OP_BRANCH:         bus.ImmSrc = 3'b010;
      OP_JAL:            bus.ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:  bus.ImmSrc = 3'b100;
      default:           bus.ImmSrc = 3'b000;
    endcase
  end

  // Strobes are gated by rst_n so they drop immediately, not one edge later.
  always_comb begin
    bus.PCWrite   = rst_n & (ctl_q.pc_write | (ctl_q.branch & taken));
    bus.MemWrite  = rst_n & ctl_q.mem_write;
    bus.IRWrite   = rst_n & ctl_q.ir_write;
    bus.RegWrite  = rst_n & ctl_q.reg_write;
    bus.IllegalOp = rst_n & (state_q == DECODE) & ~op_legal;
    bus.AdrSrc    = ctl_q.adr_src;
    bus.ResultSrc = ctl_q.result_src;
    bus.ALUSrcA   = ctl_q.alu_src_a;
    bus.ALUSrcB   = ctl_q.alu_src_b;
    bus.State     = state_q;
  end

endmodule
